// File: rtl/cart_sav_reader.sv
// Cart-RAM save export: serves HPS ioctl upload reads by fetching 16-bit words
// from the SDRAM cart-RAM region, stalling the HPS with ioctl_wait meanwhile.
module cart_sav_reader #(
  parameter logic [23:0] RAM_BASE = 24'h100000,
  parameter int          RD_LAT   = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [7:0]  ram_size,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic        upload_active,
  output logic [23:0] mem_addr,
  output logic        mem_oe,
  output logic [1:0]  mem_ds,
  input  logic [15:0] mem_dout
);

  localparam logic [2:0] LP_RD_LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_READ
  } state_t;

  state_t      r_state;
  logic [2:0]  r_ce_cnt;
  logic [15:0] r_din;
  logic        r_wait;
  logic        r_upload_active;
  logic [23:0] r_mem_addr;
  logic        r_mem_oe;

  logic [23:0] w_off;
  logic [16:0] w_limit;
  logic        w_in_range;
  logic [2:0]  w_ce_next;
  logic        w_last_ce;
  logic        w_addr_lsb_unused;

  // Save-file size in 16-bit words for the cart header RAM-size code.
  function automatic logic [16:0] word_limit(input logic [7:0] sz);
    case (sz)
      8'd1:    word_limit = 17'd1024;
      8'd2:    word_limit = 17'd4096;
      8'd3:    word_limit = 17'd16384;
      8'd4:    word_limit = 17'd65536;
      8'd5:    word_limit = 17'd32768;
      default: word_limit = 17'd0;
    endcase
  endfunction

  assign w_off             = ioctl_addr[24:1];
  assign w_addr_lsb_unused = ioctl_addr[0];
  assign w_limit           = word_limit(ram_size);
  assign w_in_range        = (w_off < {7'd0, w_limit});
  assign w_ce_next         = r_ce_cnt + 3'd1;
  assign w_last_ce         = (w_ce_next == LP_RD_LAT);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_ce_cnt        <= 3'd0;
      r_din           <= 16'd0;
      r_wait          <= 1'b0;
      r_upload_active <= 1'b0;
      r_mem_addr      <= 24'd0;
      r_mem_oe        <= 1'b0;
    end else begin
      // A dropped upload is only released once any read in flight has finished.
      if (ioctl_upload)
        r_upload_active <= 1'b1;
      else if (r_state == S_IDLE)
        r_upload_active <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (ioctl_rd && r_upload_active) begin
            if (w_in_range) begin
              r_mem_addr <= RAM_BASE + w_off;
              r_wait     <= 1'b1;
              r_state    <= S_ALIGN;
            end else begin
              r_din <= 16'hFFFF;
            end
          end
        end
        S_ALIGN: begin
          if (ce) begin
            r_mem_oe <= 1'b1;
            r_ce_cnt <= 3'd0;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (ce) begin
            r_ce_cnt <= w_ce_next;
            if (w_last_ce) begin
              r_din    <= mem_dout;
              r_mem_oe <= 1'b0;
              r_wait   <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ioctl_din     = r_din;
  assign ioctl_wait    = r_wait;
  assign upload_active = r_upload_active;
  assign mem_addr      = r_mem_addr;
  assign mem_oe        = r_mem_oe;
  assign mem_ds        = r_mem_oe ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_cart_sav_reader.sv
// Bench for cart_sav_reader: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the save-export path.
module tb_cart_sav_reader;

  localparam logic [23:0] RAM_BASE = 24'h100000;
  localparam int          RD_LAT   = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ce = 1'b0;
  logic [7:0]  ram_size = 8'd0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic        upload_active;
  logic [23:0] mem_addr;
  logic        mem_oe;
  logic [1:0]  mem_ds;
  logic [15:0] mem_dout;

  cart_sav_reader #(.RAM_BASE(RAM_BASE), .RD_LAT(RD_LAT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .ram_size(ram_size),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .upload_active(upload_active),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_ds(mem_ds), .mem_dout(mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM contents: two pinned words, everything else an address hash.
  function automatic logic [15:0] sdram_word(input logic [23:0] a);
    if (a == 24'h100000) return 16'hBEEF;
    if (a == 24'h103FFF) return 16'h1234;
    return a[15:0] ^ {a[7:0], a[15:8]} ^ {12'h0, a[19:16]} ^ 16'hA55A;
  endfunction

  assign mem_dout = sdram_word(mem_addr);

  function automatic int word_lim(input logic [7:0] s);
    case (s)
      8'd1:    return 1 << 10;
      8'd2:    return 1 << 12;
      8'd3:    return 1 << 14;
      8'd4:    return 1 << 16;
      8'd5:    return 1 << 15;
      default: return 0;
    endcase
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a read is "busy" from acceptance until the (RD_LAT+1)-th ce after it;
  // the first of those ces opens the SDRAM read, the last returns the data.
  logic        m_busy = 1'b0, m_wait = 1'b0, m_oe = 1'b0, m_ua = 1'b0;
  logic [15:0] m_din = 16'd0, m_data = 16'd0;
  logic [23:0] m_addr = 24'd0, m_off;
  int          m_ces = 0;
  logic        ua_prev, busy_prev;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_wait = 1'b0; m_oe = 1'b0; m_ua = 1'b0;
      m_din = 16'd0; m_addr = 24'd0; m_ces = 0;
    end else begin
      ua_prev   = m_ua;
      busy_prev = m_busy;
      if (ioctl_upload) m_ua = 1'b1;
      else if (!busy_prev) m_ua = 1'b0;
      if (busy_prev) begin
        if (ce) begin
          m_ces++;
          if (m_ces == 1) m_oe = 1'b1;
          if (m_ces == RD_LAT + 1) begin
            m_din = m_data; m_oe = 1'b0; m_wait = 1'b0; m_busy = 1'b0;
          end
        end
      end else if (ioctl_rd && ua_prev) begin
        m_off = ioctl_addr[24:1];
        if (int'(m_off) < word_lim(ram_size)) begin
          m_busy = 1'b1; m_ces = 0; m_wait = 1'b1;
          m_addr = RAM_BASE + m_off;
          m_data = sdram_word(RAM_BASE + m_off);
        end else begin
          m_din = 16'hFFFF;
        end
      end
    end
  end

  int oe_ce = 0, oe_rise = 0;
  logic oe_q = 1'b0;

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("ioctl_din", 32'(ioctl_din), 32'(m_din));
      check("ioctl_wait", 32'(ioctl_wait), 32'(m_wait));
      check("upload_active", 32'(upload_active), 32'(m_ua));
      check("mem_oe", 32'(mem_oe), 32'(m_oe));
      check("mem_ds", 32'(mem_ds), m_oe ? 32'd3 : 32'd0);
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
    end
    if (mem_oe && ce) oe_ce++;
    if (mem_oe && !oe_q) oe_rise++;
    oe_q = mem_oe;
  end

  int ce_phase = 0;

  task automatic step();
    @(posedge clk_sys);
    #1;
    ce_phase = (ce_phase + 1) % 8;
    ce = (ce_phase == 0);
  endtask

  task automatic do_read(input logic [24:0] a, output logic [15:0] d,
                         output int cyc, output int first_oe);
    ioctl_addr = a; ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0;
    cyc = 1; first_oe = 0;
    while (ioctl_wait && cyc < 40) begin
      step(); cyc++;
      if (mem_oe && first_oe == 0) first_oe = cyc;
    end
    check("rd_complete", 32'(ioctl_wait), 32'd0);
    d = ioctl_din;
  endtask

  logic [15:0] d;
  int cyc, foe, r0, c0, k;

  initial begin
    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check("rst_din", 32'(ioctl_din), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_ua", 32'(upload_active), 32'd0);
    check("rst_oe", 32'(mem_oe), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);

    ioctl_upload = 1'b1; step();
    check("ua_set", 32'(upload_active), 32'd1);

    // In-range read of word 0
    ram_size = 8'd2; r0 = oe_rise; c0 = oe_ce;
    do_read(25'h0, d, cyc, foe);
    check("t1_data", 32'(d), 32'hBEEF);
    check("t1_addr", 32'(mem_addr), 32'h100000);
    check("t1_oe_ce", 32'(oe_ce - c0), 32'd2);
    check("t1_oe_bursts", 32'(oe_rise - r0), 32'd1);
    check("t1_latency_ok", 32'(cyc <= 25), 32'd1);

    // Last word of a 16K-word RAM, then one past the end
    ram_size = 8'd3;
    do_read(25'h7FFE, d, cyc, foe);
    check("t2_data", 32'(d), 32'h1234);
    check("t2_addr", 32'(mem_addr), 32'h103FFF);
    r0 = oe_rise;
    do_read(25'h8000, d, cyc, foe);
    check("t2_oor_data", 32'(d), 32'hFFFF);
    check("t2_oor_cycles", 32'(cyc), 32'd1);
    check("t2_oor_oe", 32'(oe_rise - r0), 32'd0);

    // No-RAM codes, each preceded by a valid read so FFFF is a fresh result
    ram_size = 8'd4;
    do_read(25'h1FFFE, d, cyc, foe);
    check("t3_r4_data", 32'(d), 32'(sdram_word(24'h10FFFF)));
    ram_size = 8'd0; r0 = oe_rise;
    do_read(25'h0, d, cyc, foe);
    check("t3_r0_data", 32'(d), 32'hFFFF);
    ram_size = 8'd5;
    do_read(25'hFFFE, d, cyc, foe);
    check("t3_r5_data", 32'(d), 32'(sdram_word(24'h107FFF)));
    ram_size = 8'h07;
    do_read(25'h2, d, cyc, foe);
    check("t3_r7_data", 32'(d), 32'hFFFF);
    check("t3_no_access", 32'(oe_rise - r0), 32'd1);

    // Upload drops mid-read; a second request during READ is ignored
    ram_size = 8'd2; r0 = oe_rise;
    ioctl_addr = 25'h00A4; ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0;
    k = 0;
    while (!mem_oe && k < 40) begin step(); k++; end
    check("t4_oe_seen", 32'(mem_oe), 32'd1);
    ioctl_upload = 1'b0; ioctl_addr = 25'h10; ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0;
    k = 0;
    while (ioctl_wait && k < 40) begin step(); k++; end
    check("t4_done", 32'(ioctl_wait), 32'd0);
    check("t4_data", 32'(ioctl_din), 32'(sdram_word(24'h100052)));
    check("t4_ua_held", 32'(upload_active), 32'd1);
    step();
    check("t4_ua_clear", 32'(upload_active), 32'd0);
    check("t4_one_burst", 32'(oe_rise - r0), 32'd1);
    ioctl_addr = 25'h1FFFFFE; ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0; step();
    check("t4_ignored", 32'(ioctl_din), 32'(sdram_word(24'h100052)));

    // Asynchronous reset while the SDRAM read is open
    ioctl_upload = 1'b1; step(); step();
    ioctl_addr = 25'h0100; ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0;
    k = 0;
    while (!mem_oe && k < 40) begin step(); k++; end
    check("t5_oe_seen", 32'(mem_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_oe", 32'(mem_oe), 32'd0);
    check("t5_rst_wait", 32'(ioctl_wait), 32'd0);
    check("t5_rst_ua", 32'(upload_active), 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    check("t5_ua_again", 32'(upload_active), 32'd1);
    do_read(25'h0200, d, cyc, foe);
    check("t5_data", 32'(d), 32'(sdram_word(24'h100100)));

    // Request coincident with ce waits for the following ce
    k = 0;
    do begin step(); k++; end while (!ce && k < 20);
    do_read(25'h0, d, cyc, foe);
    check("t6_first_oe", 32'(foe), 32'd9);
    check("t6_data", 32'(d), 32'hBEEF);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      ioctl_rd = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) ioctl_addr = 25'($urandom_range(0, 32'h3FFFF));
      else ioctl_addr = 25'($urandom_range(0, 32'h1FFF));
      if ($urandom_range(0, 15) == 0)
        ram_size = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 79) == 0) ioctl_upload = ~ioctl_upload;
      step();
    end
    ioctl_rd = 1'b0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
